// File: rtl/stream_burst_reader_pkg.sv
// stream_burst_reader shared types: FSM states and burst counter width.
// Imported by the burst reader top and its output register.
package stream_burst_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int BCNT_W = 16;

endpackage

// File: rtl/stream_burst_reader_out_reg.sv
// stream_out_reg: single valid/ready register carrying data and last.
// A load overrides a same-cycle drain, so streaming needs no bubble.
module stream_out_reg
  import stream_burst_reader_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             last_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;

  // next state: load new word, else drop valid once it is taken
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // register the output word
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/stream_burst_reader.sv
// stream_burst_reader: drains an upstream FIFO in bursts with TLAST framing.
// Partial bursts on idle timeout exist only with STREAM_BURST_READER_TIMEOUT_EN.
module stream_burst_reader
  import stream_burst_reader_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 32,
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic [$clog2(DEPTH+1)-1:0] fifo_count,
  input  logic [WIDTH-1:0]           in0_V_V_TDATA,
  input  logic                       in0_V_V_TVALID,
  output logic                       in0_V_V_TREADY,
  output logic [WIDTH-1:0]           out_V_V_TDATA,
  output logic                       out_V_V_TVALID,
  input  logic                       out_V_V_TREADY,
  output logic                       out_V_V_TLAST,
  output logic                       busy,
  output logic [15:0]                burst_cnt
);

  localparam int CW = $clog2(DEPTH+1);

  state_e            state_q, state_d;
  logic [CW-1:0]     rem_q, rem_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              full;
  logic              pop;
  logic              in_hs;
  logic              last_hs;

  assign full = fifo_count >= CW'(BURST_LEN);
  assign pop  = (state_q == BURST) && (rem_q != '0)
             && (!out_V_V_TVALID || out_V_V_TREADY);
  assign in_hs   = pop && in0_V_V_TVALID;
  assign last_hs = out_V_V_TVALID && out_V_V_TREADY && out_V_V_TLAST;

`ifdef STREAM_BURST_READER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);

  logic [TW-1:0] tmr_q, tmr_d;
  logic          tmo;

  assign tmo = (state_q == IDLE) && (tmr_q == TW'(TIMEOUT-1))
            && (fifo_count != '0) && !full;

  // idle wait timer: counts while words sit below a full burst
  always_comb begin
    tmr_d = '0;
    if ((state_q == IDLE) && (fifo_count != '0) && !full && !tmo)
      tmr_d = tmr_q + TW'(1);
  end

  // timer register
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) tmr_q <= '0;
    else        tmr_q <= tmr_d;
  end
`endif

  // FSM next state, remaining words and completed-burst count
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    bcnt_d  = bcnt_q;
    unique case (state_q)
      IDLE: begin
        if (full) begin
          state_d = BURST;
          rem_d   = CW'(BURST_LEN);
        end
`ifdef STREAM_BURST_READER_TIMEOUT_EN
        else if (tmo) begin
          state_d = BURST;
          rem_d   = fifo_count;
        end
`endif
      end
      BURST: begin
        if (in_hs) begin
          rem_d = rem_q - CW'(1);
          if (rem_q == CW'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_hs) begin
          state_d = IDLE;
          if (bcnt_q != '1) bcnt_d = bcnt_q + BCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state registers
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      bcnt_q  <= bcnt_d;
    end
  end

  stream_out_reg #(
    .WIDTH (WIDTH)
  ) u_out (
    .clk_i   (ap_clk),
    .rst_i   (ap_rst),
    .load_i  (in_hs),
    .data_i  (in0_V_V_TDATA),
    .last_i  (rem_q == CW'(1)),
    .ready_i (out_V_V_TREADY),
    .valid_o (out_V_V_TVALID),
    .data_o  (out_V_V_TDATA),
    .last_o  (out_V_V_TLAST)
  );

  assign in0_V_V_TREADY = pop;
  assign busy           = state_q != IDLE;
  assign burst_cnt      = bcnt_q;

endmodule

// File: tb/tb_stream_burst_reader.sv
// Scoreboard bench for stream_burst_reader with a queue-backed FIFO model.
// Timeout checks follow STREAM_BURST_READER_TIMEOUT_EN.
module tb_stream_burst_reader;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic [5:0]  fifo_count = '0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        busy;
  logic [15:0] burst_cnt;

  stream_burst_reader dut (
    .ap_clk         (ap_clk),
    .ap_rst         (ap_rst),
    .fifo_count     (fifo_count),
    .in0_V_V_TDATA  (in_data),
    .in0_V_V_TVALID (in_valid),
    .in0_V_V_TREADY (in_ready),
    .out_V_V_TDATA  (out_data),
    .out_V_V_TVALID (out_valid),
    .out_V_V_TREADY (out_ready),
    .out_V_V_TLAST  (out_last),
    .busy           (busy),
    .burst_cnt      (burst_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  logic [15:0] fifo_q[$];
  logic [16:0] exp_q[$];
  int          hs_cyc[$];
  int          errors = 0;
  int          checks = 0;
  int          out_count = 0;
  int          last_count = 0;
  int          cyc = 0;
  logic        stall_in = 1'b0;

  logic [15:0] b2b [16] = '{
    16'hA5A5, 16'h1234, 16'hFFFF, 16'h0000,
    16'h8001, 16'h7FFE, 16'hBEEF, 16'hCAFE,
    16'h0F0F, 16'hF0F0, 16'h5555, 16'hAAAA,
    16'hDEAD, 16'h0042, 16'h1001, 16'hC3C3
  };

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ap_clk);
      #2;
    end
  endtask

  task automatic wait_outs(input int n, input int budget, input string name);
    int c = 0;
    while (out_count < n && c < budget) begin
      @(posedge ap_clk);
      #2;
      c++;
    end
    checks++;
    if (out_count < n) begin
      errors++;
      $display("FAIL %s: got %0d outputs want %0d (timeout)", name,
               out_count, n);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic last);
    fifo_q.push_back(d);
    exp_q.push_back({last, d});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " valid"}, out_valid, 0);
    chk({tag, " last"}, out_last, 0);
    chk({tag, " data"}, out_data, 0);
    chk({tag, " in_ready"}, in_ready, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " burst_cnt"}, burst_cnt, 0);
  endtask

  // upstream FIFO model: pop on handshake, present head after the edge
  initial forever begin
    @(posedge ap_clk);
    if (!ap_rst && in_ready && in_valid && fifo_q.size() > 0)
      fifo_q.delete(0);
    #1;
    fifo_count = 6'(fifo_q.size());
    in_valid   = (fifo_q.size() > 0) && !stall_in;
    in_data    = (fifo_q.size() > 0) ? fifo_q[0] : 16'h0;
  end

  // monitor: compare every output handshake and check holds during stalls
  initial begin
    logic        pv;
    logic [16:0] pw;
    logic [16:0] e;
    pv = 1'b0;
    pw = '0;
    forever begin
      @(negedge ap_clk);
      cyc++;
      if (ap_rst) begin
        pv = 1'b0;
      end else begin
        if (pv) begin
          checks++;
          if (!out_valid || {out_last, out_data} !== pw) begin
            errors++;
            $display("FAIL hold: got v=%b %h want v=1 %h", out_valid,
                     {out_last, out_data}, pw);
          end
        end
        pv = out_valid && !out_ready;
        pw = {out_last, out_data};
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected: got %h want nothing",
                     {out_last, out_data});
          end else begin
            e = exp_q.pop_front();
            if ({out_last, out_data} !== e) begin
              errors++;
              $display("FAIL word: got %h want %h", {out_last, out_data}, e);
            end
          end
          out_count++;
          if (out_last) last_count++;
          hs_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    tick(3);
    chk_reset("rst0");
    ap_rst = 1'b0;
    tick(2);
    out_ready = 1'b1;

    // one full burst, one word per cycle
    for (int i = 1; i <= 8; i++) push(16'(i), i == 8);
    wait_outs(8, 40, "burst1");
    tick(2);
    chk("burst1 span", hs_cyc[7] - hs_cyc[0], 7);
    chk("burst1 cnt", burst_cnt, 1);
    chk("burst1 tlast", last_count, 1);
    chk("burst1 busy", busy, 0);

    // output stall while the 4th word is presented
    for (int i = 1; i <= 8; i++) push(16'h0100 + 16'(i), i == 8);
    wait_outs(11, 40, "stall pre");
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("stall data", out_data, 16'h0104);
      chk("stall in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    wait_outs(16, 40, "stall post");
    tick(2);
    chk("stall cnt", burst_cnt, 2);
    chk("stall tlast", last_count, 2);

    // reset after the 3rd word of a burst
    for (int i = 1; i <= 8; i++) push(16'h0200 + 16'(i), i == 8);
    wait_outs(19, 40, "rst pre");
    ap_rst = 1'b1;
    #1;
    chk_reset("rst mid");
    fifo_q.delete();
    exp_q.delete();
    tick(2);
    chk("rst in_ready", in_ready, 0);
    ap_rst = 1'b0;
    tick(2);
    chk("rst no tlast", last_count, 2);

    // fresh burst with an input stall inside it
    for (int i = 1; i <= 8; i++) push(16'h0300 + 16'(i), i == 8);
    tick(4);
    stall_in = 1'b1;
    tick(3);
    stall_in = 1'b0;
    wait_outs(out_count + exp_q.size(), 60, "post rst");
    tick(2);
    chk("post rst cnt", burst_cnt, 1);
    chk("post rst tlast", last_count, 3);

    // two back-to-back bursts from a clean reset
    ap_rst = 1'b1;
    tick(1);
    ap_rst = 1'b0;
    tick(2);
    for (int i = 0; i < 16; i++) push(b2b[i], i == 7 || i == 15);
    wait_outs(out_count + 16, 80, "b2b");
    tick(2);
    chk("b2b cnt", burst_cnt, 2);
    chk("b2b tlast", last_count, 5);
    chk("b2b leftover", exp_q.size(), 0);

    // residual words below a full burst
`ifdef STREAM_BURST_READER_TIMEOUT_EN
    for (int i = 1; i <= 3; i++) push(16'h0400 + 16'(i), i == 3);
    tick(50);
    chk("tmo early", out_count, 43);
    wait_outs(46, 40, "tmo burst");
    tick(2);
    chk("tmo tlast", last_count, 6);
    chk("tmo cnt", burst_cnt, 3);
`else
    for (int i = 1; i <= 3; i++) fifo_q.push_back(16'h0400 + 16'(i));
    tick(200);
    chk("no tmo out", out_count, 43);
    chk("no tmo busy", busy, 0);
    chk("no tmo count", fifo_count, 3);
`endif
    chk("final leftover", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_burst_reader.md
STREAM_BURST_READER -- requirements
Module: stream_burst_reader

Interface
REQ-001 Parameter WIDTH, default 16: stream data width in bits.
REQ-002 Parameter DEPTH, default 32: depth of the upstream FIFO being drained.
REQ-003 Parameter BURST_LEN, default 8, range 1..DEPTH: words per full burst.
REQ-004 Parameter TIMEOUT, default 64, minimum 1: idle cycles before a partial burst is issued.
REQ-005 ap_clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 ap_rst  input  1  asynchronous, active-high reset.
REQ-007 fifo_count  input  $clog2(DEPTH+1)  occupancy reported by the upstream FIFO.
REQ-008 in0_V_V_TDATA  input  WIDTH  upstream FIFO read data.
REQ-009 in0_V_V_TVALID  input  1  upstream data valid.
REQ-010 in0_V_V_TREADY  output  1  pop request to the upstream FIFO.
REQ-011 out_V_V_TDATA  output  WIDTH  burst data.
REQ-012 out_V_V_TVALID  output  1  output data valid.
REQ-013 out_V_V_TREADY  input  1  downstream ready.
REQ-014 out_V_V_TLAST  output  1  marks the final word of each burst.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 burst_cnt  output  16  count of completed bursts, saturating at 16'hFFFF.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, BURST, DRAIN.
REQ-018 In IDLE: in0_V_V_TREADY=0; the wait timer increments each cycle with fifo_count>0 and clears when fifo_count==0.
REQ-019 IDLE->BURST when fifo_count>=BURST_LEN, latching remaining=BURST_LEN; this condition takes priority over timeout.
REQ-020 IDLE->BURST on timeout (timer==TIMEOUT-1 and 0<fifo_count<BURST_LEN), latching remaining=fifo_count.
REQ-021 In BURST: in0_V_V_TREADY = (remaining>0) && (!out_V_V_TVALID || out_V_V_TREADY).
- An input handshake loads a single output register, sets out_V_V_TVALID, and decrements remaining.
REQ-022 Latency SHALL be exactly 1 cycle from the input handshake to out_V_V_TVALID; no combinational path from in0 TDATA/TVALID to out.
REQ-023 A simultaneous output handshake and input handshake SHALL replace the register content with no bubble, sustaining one word per cycle.
REQ-024 out_V_V_TLAST=1 exactly on the word loaded when remaining==1.
REQ-025 BURST->DRAIN on the input handshake that takes remaining to 0.
REQ-026 DRAIN->IDLE on the output handshake of the TLAST word; burst_cnt increments on that cycle; the timer clears.
REQ-027 out_V_V_TDATA, out_V_V_TVALID and out_V_V_TLAST SHALL hold stable while TVALID=1 and TREADY=0.
REQ-028 An input stall (TVALID=0) inside a burst SHALL neither abort the burst nor advance remaining.

Reset
REQ-029 ap_rst asserted at any time, including mid-burst, SHALL immediately force:
- state=IDLE, timer=0, remaining=0, burst_cnt=0;
- out_V_V_TVALID=0, out_V_V_TLAST=0, out_V_V_TDATA=0, in0_V_V_TREADY=0, busy=0.
REQ-030 After reset, a partially emitted burst is discarded with no TLAST; words left in the upstream FIFO stay unconsumed.

Configuration
REQ-031 Macro STREAM_BURST_READER_TIMEOUT_EN SHALL control partial bursts.
- Defined: the timer and REQ-020 are present.
- Undefined: no timer logic is present; only full BURST_LEN bursts are issued, and residual words wait indefinitely.

Structure
REQ-032 A shared package SHALL hold the FSM state enum (IDLE, BURST, DRAIN) and the burst_cnt width constant (16).
REQ-033 The output register stage SHALL be one sub-module, stream_out_reg (valid/ready register carrying data and last).

Verification
REQ-034 fifo_count=8, 8 words 0x0001..0x0008, out_V_V_TREADY=1 -> 8 consecutive outputs, TLAST only on 0x0008, burst_cnt=1.
REQ-035 Macro defined, fifo_count=3 held for 64 cycles -> a burst of 3 words with TLAST on the third; macro undefined -> no output after 200 cycles.
REQ-036 out_V_V_TREADY=0 for 5 cycles during the 4th word -> data held stable, in0_V_V_TREADY=0, no loss or duplication.
REQ-037 ap_rst pulsed after the 3rd word of a full burst -> all outputs at reset values; the next full burst starts from IDLE with a correct TLAST.
REQ-038 Two back-to-back full bursts of random data -> the output sequence matches the input, with 2 TLAST pulses and burst_cnt=2.
